sync_fifo_fwft: RTL and testbench
=================================

Name: sync_fifo_fwft

Overview:
- Single-clock parametrised FIFO; next generation of the team's FIFO family for same-domain buffering, e.g. ping-pong bank feeding and rate smoothing.
- Adds a runtime-fixed read mode: standard (1-cycle read latency) or first-word-fall-through (FWFT).
- Adds programmable full/empty thresholds, a valid strobe, and overflow/underflow error pulses.
- Memory is a separate dual-port RAM sub-module; all control and flags live here.

Parameters:
DATA_SIZE, 16, data width in bits
DEPTH_SIZE, 10, log2 of RAM depth (10 gives 1024 entries)
FWFT_EN, 0, 0 = standard read mode, 1 = first-word-fall-through
FULL_THR, 512, prog_full assert level (data_count >= FULL_THR)
FULL_THR_EN, 1, 0 forces prog_full to 0
EMPTY_THR, 4, prog_empty assert level (data_count <= EMPTY_THR)

Ports:
clk  input  1  single clock for all logic, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write request
din  input  DATA_SIZE  write data
rd_en  input  1  read request (standard mode) or pop/acknowledge (FWFT mode)
dout  output  DATA_SIZE  read data
valid  output  1  dout holds a newly read word (standard) or the head word (FWFT)
full  output  1  RAM occupancy == 2^DEPTH_SIZE
empty  output  1  no word readable
data_count  output  DEPTH_SIZE+1  words held, including the FWFT output register
prog_full  output  1  threshold full
prog_empty  output  1  threshold empty
overflow  output  1  1-cycle pulse: write rejected
underflow  output  1  1-cycle pulse: read rejected

Behaviour:
- Reset (async assert, sync release by upstream):
  - wr_ptr, rd_ptr = 0; dout = 0; valid = 0; empty = 1; full = 0; data_count = 0.
  - prog_full = 0; prog_empty = 1; overflow = 0; underflow = 0.
  - RAM contents are not reset.
- Pointers: DEPTH_SIZE+1-bit binary; the MSB is the wrap bit; the RAM address is the low DEPTH_SIZE bits.
  - RAM occupancy = wr_ptr - rd_ptr, modulo 2^(DEPTH_SIZE+1).
- Write: accepted when wr_en && !full, using full as registered at the edge. wr_ptr increments on the same edge.
  - wr_en && full: write dropped, pointer unchanged, overflow = 1 for the following cycle.
  - Write is rejected when full even if a read occurs in the same cycle.
- Standard mode (FWFT_EN=0):
  - Read accepted when rd_en && !empty. dout and valid=1 appear the cycle after acceptance (latency 1).
  - valid = 0 in cycles with no accepted read; dout holds its last value.
  - rd_en && empty: underflow pulse, dout unchanged.
  - empty = (occupancy == 0).
- FWFT mode (FWFT_EN=1):
  - Internal prefetch state machine with states EMPTY, FETCH, HOLD.
  - EMPTY -> FETCH when occupancy > 0. A RAM read is issued in FETCH.
  - FETCH -> HOLD on the next edge: dout loaded, valid = 1.
  - HOLD with rd_en: pop. If occupancy > 0, reload dout on the same edge (stay in HOLD, no bubble); otherwise go to EMPTY.
  - First word written to an empty FIFO at edge k is visible (valid = 1) after edge k+2.
  - empty = !valid. rd_en && !valid: underflow pulse.
  - Total capacity = 2^DEPTH_SIZE + 1 (RAM plus output register); full still reflects RAM occupancy only.
- data_count = occupancy + (FWFT_EN ? valid : 0). Registered, updated on the same edge as the pointers.
  - Simultaneous accepted read and write leaves data_count unchanged.
- prog_full = FULL_THR_EN && data_count >= FULL_THR. prog_empty = data_count <= EMPTY_THR. Both registered, same timing as data_count.
- Wrap-around: pointers roll over silently. full/empty remain correct across any number of wraps.
- Reset asserted mid-burst: all state clears immediately, and no RAM write occurs while rst_n = 0.

Decomposition:
- Shared package/header holds:
  - the FWFT state encodings (ST_EMPTY, ST_FETCH, ST_HOLD);
  - the DEPTH/DEPTH_SIZE derived constants;
  - the pointer-compare helper used by the FIFO family.
- One sub-module: sync_fifo_mem — simple dual-port RAM, one clock, registered read port. Reused by the async variant with separate clocks.

Test Plan:
- DEPTH_SIZE=4, FWFT_EN=0: write 16 words 0x0..0xF -> full=1, data_count=16, prog_full per FULL_THR=8. A 17th write gives overflow=1 for one cycle and data_count stays 16.
- Same config: read 16 words back-to-back -> dout=0x0..0xF, each one cycle after rd_en, valid high 16 cycles. Then empty=1, and a 17th rd_en gives underflow=1.
- DEPTH_SIZE=4, FWFT_EN=1: a single write of 0xA5 at edge k -> valid=1 and dout=0xA5 after edge k+2, empty=0. Pop -> valid=0, empty=1.
- FWFT: preload 20 words (16 RAM + output reg, the 18th gives overflow), then rd_en held -> 17 consecutive words with no bubble cycle.
- Simultaneous wr_en and rd_en for 100 cycles at data_count=5 -> data_count constant at 5, ordering preserved across multiple pointer wraps.
- Assert rst_n low mid-burst -> all outputs return to reset values asynchronously. After release, the first write/read pair returns the new data only.

Source files
------------

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared definitions for the single-clock FIFO family: prefetch states,
// depth constants and the pointer occupancy helper.
package sync_fifo_fwft_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fwft_state_t;

    localparam int DEFAULT_DATA_SIZE  = 16;
    localparam int DEFAULT_DEPTH_SIZE = 10;

    function automatic int unsigned depth_of(input int unsigned depth_size);
        return 32'd1 << depth_size;
    endfunction

    // Pointers are depth_size+1 bits wide; the extra MSB is the wrap bit, so the
    // modular difference distinguishes a full RAM from an empty one.
    function automatic logic [31:0] ptr_occupancy(input logic [31:0] wr_ptr,
                                                  input logic [31:0] rd_ptr,
                                                  input int unsigned depth_size);
        logic [31:0] mask;
        mask = (32'd1 << (depth_size + 1)) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM with a registered read port. Separate port clocks so the
// async FIFO variant can share it; only the read register is resettable.
module sync_fifo_mem #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 wr_clk,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DATA_SIZE-1:0] ram [DEPTH];

    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= ram[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable thresholds and overflow/underflow pulses.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int DEPTH_SIZE  = DEFAULT_DEPTH_SIZE,
    parameter int FWFT_EN     = 0,
    parameter int FULL_THR    = 512,
    parameter int FULL_THR_EN = 1,
    parameter int EMPTY_THR   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_SIZE-1:0]  din,
    input  logic                  rd_en,
    output logic [DATA_SIZE-1:0]  dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_SIZE:0]   data_count,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = DEPTH_SIZE + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(depth_of(DEPTH_SIZE));

    logic [PTR_W-1:0] wr_ptr, rd_ptr, occupancy;
    logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next, count_next;
    logic             wr_acc, ram_rd, valid_next;
    fwft_state_t      state, state_next;

    assign occupancy = PTR_W'(ptr_occupancy(32'(wr_ptr), 32'(rd_ptr), DEPTH_SIZE));
    assign full      = (occupancy == DEPTH_P);
    assign empty     = (FWFT_EN != 0) ? !valid : (occupancy == '0);
    assign wr_acc    = wr_en && !full;

    // Read control: in FWFT mode the prefetcher owns the RAM read port and
    // rd_en only pops the output register; in standard mode rd_en reads directly.
    always_comb begin
        state_next = state;
        ram_rd     = 1'b0;
        valid_next = 1'b0;
        if (FWFT_EN != 0) begin
            unique case (state)
                ST_EMPTY: begin
                    if (occupancy != '0) begin
                        state_next = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ram_rd     = 1'b1;
                    state_next = ST_HOLD;
                end
                ST_HOLD: begin
                    if (rd_en) begin
                        if (occupancy != '0) begin
                            ram_rd = 1'b1;
                        end else begin
                            state_next = ST_EMPTY;
                        end
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
            valid_next = (state_next == ST_HOLD);
        end else begin
            ram_rd     = rd_en && (occupancy != '0);
            valid_next = ram_rd;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr + PTR_W'(wr_acc);
        rd_ptr_next = rd_ptr + PTR_W'(ram_rd);
        count_next  = PTR_W'(ptr_occupancy(32'(wr_ptr_next), 32'(rd_ptr_next), DEPTH_SIZE));
        if (FWFT_EN != 0) begin
            count_next = count_next + PTR_W'(valid_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= ST_EMPTY;
            valid      <= 1'b0;
            data_count <= '0;
            prog_full  <= 1'b0;
            prog_empty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            state      <= state_next;
            valid      <= valid_next;
            data_count <= count_next;
            prog_full  <= (FULL_THR_EN != 0) && (int'(count_next) >= FULL_THR);
            prog_empty <= (int'(count_next) <= EMPTY_THR);
            overflow   <= wr_en && full;
            underflow  <= rd_en && empty;
        end
    end

    // Writes are gated by rst_n so nothing lands in the RAM while reset is held.
    sync_fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (DEPTH_SIZE)
    ) u_mem (
        .wr_clk   (clk),
        .wr_en    (wr_acc && rst_n),
        .wr_addr  (wr_ptr[DEPTH_SIZE-1:0]),
        .wr_data  (din),
        .rd_clk   (clk),
        .rd_rst_n (rst_n),
        .rd_en    (ram_rd),
        .rd_addr  (rd_ptr[DEPTH_SIZE-1:0]),
        .rd_data  (dout)
    );

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: a standard-mode and an FWFT-mode instance share the
// same stimulus and are each checked against a queue-based reference model.
module tb_sync_fifo_fwft;

    localparam int DW    = 16;
    localparam int DS    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = DS + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_valid, s_full, s_empty, s_prog_full, s_prog_empty, s_overflow, s_underflow;
    logic          f_valid, f_full, f_empty, f_prog_full, f_prog_empty, f_overflow, f_underflow;
    logic [CW-1:0] s_data_count, f_data_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sq[$];
    logic [DW-1:0] s_exp_dout;
    logic          s_exp_valid, s_exp_ovf, s_exp_unf;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] f_head;
    logic          f_has, f_wait, f_exp_ovf, f_exp_unf;

    always #5 clk = ~clk;

    sync_fifo_fwft #(
        .DATA_SIZE(DW), .DEPTH_SIZE(DS), .FWFT_EN(0),
        .FULL_THR(8), .FULL_THR_EN(1), .EMPTY_THR(4)
    ) dut_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
        .data_count(s_data_count), .prog_full(s_prog_full), .prog_empty(s_prog_empty),
        .overflow(s_overflow), .underflow(s_underflow)
    );

    sync_fifo_fwft #(
        .DATA_SIZE(DW), .DEPTH_SIZE(DS), .FWFT_EN(1),
        .FULL_THR(8), .FULL_THR_EN(1), .EMPTY_THR(4)
    ) dut_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
        .data_count(f_data_count), .prog_full(f_prog_full), .prog_empty(f_prog_empty),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        fq.delete();
        s_exp_dout  = '0;
        s_exp_valid = 1'b0;
        s_exp_ovf   = 1'b0;
        s_exp_unf   = 1'b0;
        f_head      = '0;
        f_has       = 1'b0;
        f_wait      = 1'b0;
        f_exp_ovf   = 1'b0;
        f_exp_unf   = 1'b0;
    endtask

    // Standard mode: a plain bounded queue, popped word shows on dout after the edge.
    task automatic std_model_step(input logic wr, input logic rd, input logic [DW-1:0] d);
        s_exp_ovf   = wr && (sq.size() == DEPTH);
        s_exp_unf   = rd && (sq.size() == 0);
        s_exp_valid = 1'b0;
        if (rd && sq.size() > 0) begin
            s_exp_dout  = sq.pop_front();
            s_exp_valid = 1'b1;
        end
        if (wr && !s_exp_ovf) sq.push_back(d);
    endtask

    // FWFT mode: RAM queue plus a head register; with no head, a waiting word
    // becomes the head on the second edge it is available.
    task automatic fwft_model_step(input logic wr, input logic rd, input logic [DW-1:0] d);
        int ram_n;
        ram_n     = fq.size();
        f_exp_ovf = wr && (ram_n == DEPTH);
        f_exp_unf = rd && !f_has;
        if (f_has) begin
            if (rd) begin
                if (ram_n > 0) f_head = fq.pop_front();
                else           f_has  = 1'b0;
            end
        end else if (ram_n > 0) begin
            if (f_wait) begin
                f_head = fq.pop_front();
                f_has  = 1'b1;
                f_wait = 1'b0;
            end else begin
                f_wait = 1'b1;
            end
        end
        if (wr && !f_exp_ovf) fq.push_back(d);
    endtask

    task automatic check_output();
        int sc, fc;
        sc = sq.size();
        fc = fq.size() + int'(f_has);
        check("std.valid",      32'(s_valid),      32'(s_exp_valid));
        check("std.dout",       32'(s_dout),       32'(s_exp_dout));
        check("std.empty",      32'(s_empty),      32'(sc == 0));
        check("std.full",       32'(s_full),       32'(sc == DEPTH));
        check("std.count",      32'(s_data_count), 32'(sc));
        check("std.prog_full",  32'(s_prog_full),  32'(sc >= 8));
        check("std.prog_empty", 32'(s_prog_empty), 32'(sc <= 4));
        check("std.overflow",   32'(s_overflow),   32'(s_exp_ovf));
        check("std.underflow",  32'(s_underflow),  32'(s_exp_unf));
        check("fwft.valid",     32'(f_valid),      32'(f_has));
        if (f_has) check("fwft.dout", 32'(f_dout), 32'(f_head));
        check("fwft.empty",     32'(f_empty),      32'(!f_has));
        check("fwft.full",      32'(f_full),       32'(fq.size() == DEPTH));
        check("fwft.count",     32'(f_data_count), 32'(fc));
        check("fwft.prog_full", 32'(f_prog_full),  32'(fc >= 8));
        check("fwft.prog_empty",32'(f_prog_empty), 32'(fc <= 4));
        check("fwft.overflow",  32'(f_overflow),   32'(f_exp_ovf));
        check("fwft.underflow", 32'(f_underflow),  32'(f_exp_unf));
    endtask

    task automatic apply_stimulus(input logic wr, input logic rd, input logic [DW-1:0] d);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        std_model_step(wr, rd, d);
        fwft_model_step(wr, rd, d);
        #1;
        check_output();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output();
        check("fwft.dout_reset", 32'(f_dout), 32'h0);
        rst_n = 1'b1;

        // Fill: 16 words fill the standard RAM, the 17th overflows there.
        for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 1'b0, DW'(i));
        check("std.overflow_17th", 32'(s_overflow), 32'h1);
        check("std.count_full", 32'(s_data_count), 32'd16);

        // Drain back-to-back; the 17th read underflows in standard mode.
        for (int i = 0; i < 17; i++) apply_stimulus(1'b0, 1'b1, '0);
        check("std.underflow_17th", 32'(s_underflow), 32'h1);
        repeat (3) apply_stimulus(1'b0, 1'b1, '0);

        // Single word into an empty FWFT FIFO, visible two edges later, then popped.
        apply_stimulus(1'b1, 1'b0, 16'h00A5);
        check("fwft.not_yet_valid", 32'(f_valid), 32'h0);
        apply_stimulus(1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, '0);
        check("fwft.a5_visible", 32'(f_dout), 32'h00A5);
        apply_stimulus(1'b0, 1'b1, '0);
        apply_stimulus(1'b0, 1'b0, '0);

        // Preload 20 words, then hold rd_en: FWFT must stream 17 with no bubble.
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, DW'(16'h0100 + i));
        repeat (2) apply_stimulus(1'b0, 1'b0, '0);
        check("fwft.count_capacity", 32'(f_data_count), 32'd17);
        for (int i = 0; i < 18; i++) begin
            if (i < 17) check("fwft.nobubble", 32'(f_valid), 32'h1);
            apply_stimulus(1'b0, 1'b1, '0);
        end
        repeat (2) apply_stimulus(1'b0, 1'b0, '0);

        // Hold occupancy at 5 with simultaneous traffic across several wraps.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, DW'(16'h0200 + i));
        repeat (3) apply_stimulus(1'b0, 1'b0, '0);
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(1'b1, 1'b1, DW'($urandom));
            check("std.count_steady", 32'(s_data_count), 32'd5);
            check("fwft.count_steady", 32'(f_data_count), 32'd5);
        end

        // Random traffic, write-heavy then read-heavy.
        for (int i = 0; i < 300; i++) begin
            logic w, r;
            w = ($urandom_range(0, 99) < ((i < 150) ? 70 : 30));
            r = ($urandom_range(0, 99) < ((i < 150) ? 30 : 70));
            apply_stimulus(w, r, DW'($urandom));
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'(i % 2), DW'(16'h0300 + i));
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output();
        check("fwft.dout_async_reset", 32'(f_dout), 32'h0);
        wr_en = 1'b1;
        din   = 16'hDEAD;
        @(posedge clk);
        #1;
        check_output();
        rst_n = 1'b1;
        wr_en = 1'b0;
        apply_stimulus(1'b1, 1'b0, 16'hBEEF);
        apply_stimulus(1'b0, 1'b1, '0);
        check("std.after_reset_data", 32'(s_dout), 32'hBEEF);
        apply_stimulus(1'b0, 1'b0, '0);
        check("fwft.after_reset_data", 32'(f_dout), 32'hBEEF);
        apply_stimulus(1'b0, 1'b1, '0);
        repeat (2) apply_stimulus(1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
